// File: rtl/ring_scan_pkg.sv
// Shared state type, blank pattern and hex-to-7-segment table for the display scan stage.
package ring_scan_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Segment order gfedcba, active-low, for a common-anode display.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/ring_scan_mux_hex7_decode.sv
// Combinational nibble to active-low 7-segment decoder.
module hex7_decode
    import ring_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex7(nibble);

endmodule

// File: rtl/ring_scan_mux.sv
// Ring-counter driven display scan with anti-ghost blanking and tear-free frame buffering.
// Optional illegal-phase fault tracking is enabled by defining SCAN_FAULT_CHECK_EN.
module ring_scan_mux
    import ring_scan_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int BLANK_CYC = 2,
    parameter int ERR_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_DIG-1:0]     phase,
    input  logic [4*N_DIG-1:0]   digit_data,
    input  logic                 load,
    output logic [6:0]           seg,
    output logic [N_DIG-1:0]     an,
    output logic                 frame_done,
    output logic                 fault,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int CNT_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] CNT_RELOAD = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

    scan_state_t          state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [N_DIG-1:0]     phase_q;
    logic [4*N_DIG-1:0]   shadow, shadow_nxt, pend;
    logic                 pend_vld;
    logic                 chg, legal, xfer;
    logic [3:0]           sel_nib;
    logic [6:0]           dec_seg;

    assign chg   = (phase != phase_q);
    assign legal = (phase != '0) && ((phase & (phase - N_DIG'(1))) == '0);
    // Without a pending load, pend already equals shadow, so skipping the copy is harmless.
    assign xfer       = chg && (phase == N_DIG'(1)) && pend_vld;
    assign shadow_nxt = xfer ? pend : shadow;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!legal) begin
`ifdef SCAN_FAULT_CHECK_EN
            state_nxt = FAULT;
`else
            state_nxt = BLANK;
            cnt_nxt   = CNT_RELOAD;
`endif
        end else if (chg || (state == FAULT)) begin
            if (BLANK_CYC == 0) begin
                state_nxt = DRIVE;
            end else begin
                state_nxt = BLANK;
                cnt_nxt   = CNT_RELOAD;
            end
        end else if (state == BLANK) begin
            if (cnt == '0) begin
                state_nxt = DRIVE;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    // Outputs are registered from next-cycle values so they line up with the state they belong to.
    always_comb begin
        sel_nib = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (phase[i]) begin
                sel_nib = sel_nib | shadow_nxt[4*i +: 4];
            end
        end
    end

    hex7_decode u_dec (
        .nibble (sel_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BLANK;
            cnt        <= CNT_INIT;
            phase_q    <= '0;
            shadow     <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            an         <= '1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            phase_q    <= phase;
            shadow     <= shadow_nxt;
            frame_done <= phase_q[N_DIG-1] & phase[0];
            if (load) begin
                pend     <= digit_data;
                pend_vld <= 1'b1;
            end else if (xfer) begin
                pend_vld <= 1'b0;
            end
            if (state_nxt == DRIVE) begin
                an  <= ~phase;
                seg <= dec_seg;
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
            end
        end
    end

`ifdef SCAN_FAULT_CHECK_EN
    logic enter_fault;

    assign enter_fault = !legal && (state != FAULT);

    // Counts entries into FAULT only, so a long glitch is one event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault   <= 1'b0;
            err_cnt <= '0;
        end else if (enter_fault) begin
            fault <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end
`else
    assign fault   = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_scan_mux.sv
// Randomized, self-checking bench for ring_scan_mux against a cycle-level behavioural model.
// Follows SCAN_FAULT_CHECK_EN to choose the expected fault behaviour.
module tb_ring_scan_mux;

    localparam int N_DIG     = 4;
    localparam int BLANK_CYC = 2;
    localparam int ERR_W     = 8;
`ifdef SCAN_FAULT_CHECK_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  phase;
    logic [15:0] digit_data;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        fault;
    logic [7:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ring_scan_mux #(.N_DIG(N_DIG), .BLANK_CYC(BLANK_CYC), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase),
        .digit_data (digit_data),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .fault      (fault),
        .err_cnt    (err_cnt)
    );

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] want_4321 [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
    logic [6:0] want_abcd [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
    int illegal_tab [12] = '{0, 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    // Behavioural model: remaining blank cycles, fault flag, pending and displayed nibbles.
    int         m_prev, m_rem, m_err;
    bit         m_in_fault, m_fault;
    int         m_pend [4];
    int         m_shown [4];
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_fd;

    task automatic model_reset();
        m_prev     = 0;
        m_rem      = BLANK_CYC + 1;
        m_err      = 0;
        m_in_fault = 0;
        m_fault    = 0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i]  = 0;
            m_shown[i] = 0;
        end
        exp_seg = 7'h7F;
        exp_an  = 4'hF;
        exp_fd  = 1'b0;
    endtask

    task automatic model_edge();
        int  p;
        int  idx;
        bit  legal;
        bit  show;
        p      = int'(phase);
        legal  = (p != 0) && ((p & (p - 1)) == 0);
        exp_fd = ((m_prev & 8) != 0) && ((p & 1) != 0);
        if (p != m_prev && p == 1) m_shown = m_pend;
        if (load) begin
            for (int i = 0; i < 4; i++) m_pend[i] = int'(digit_data[4*i +: 4]);
        end
        show = 0;
        if (!legal) begin
            if (FAULT_EN) begin
                if (!m_in_fault) begin
                    m_fault = 1;
                    if (m_err < 255) m_err++;
                end
                m_in_fault = 1;
            end
        end else begin
            if (p != m_prev || m_in_fault) m_rem = BLANK_CYC;
            m_in_fault = 0;
            show = (m_rem == 0);
            if (m_rem > 0) m_rem--;
        end
        m_prev = p;
        if (show) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (p == (1 << i)) idx = i;
            exp_an  = ~4'(p);
            exp_seg = hex_tab[m_shown[idx]];
        end else begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [3:0] p, input bit ld, input logic [15:0] data);
        phase = p;
        load  = ld;
        if (ld) digit_data = data;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (seg !== 7'h7F) begin
            miscompares++;
            $display("[TB] FAIL reset_seg got %h want 7f", seg);
        end
        vectors++;
        if (an !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL reset_an got %h want f", an);
        end
        vectors++;
        if ({frame_done, fault, err_cnt} !== 10'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got fd=%b fault=%b err=%h want 0/0/00", frame_done, fault, err_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        logic [3:0] oh;
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                oh = 4'b0001 << d;
                for (int c = 0; c < 4; c++) begin
                    drive(oh, (f == 0 && d == 0 && c == 0), 16'h4321);
                    vectors++;
                    if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                        miscompares++;
                        $display("[TB] FAIL scan t=%0t seg/an/fd got %h/%h/%b want %h/%h/%b",
                                 $time, seg, an, frame_done, exp_seg, exp_an, exp_fd);
                    end
                end
                if (f == 1) begin
                    vectors++;
                    if (seg !== want_4321[d] || an !== ~oh) begin
                        miscompares++;
                        $display("[TB] FAIL scan_digit%0d got seg=%h an=%h want seg=%h an=%h",
                                 d, seg, an, want_4321[d], ~oh);
                    end
                end
            end
        end
    endtask

    task automatic test_load_mid_frame();
        logic [3:0] oh;
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                oh = 4'b0001 << d;
                for (int c = 0; c < 4; c++) begin
                    drive(oh, (f == 0 && d == 2 && c == 0), 16'hABCD);
                    vectors++;
                    if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                        miscompares++;
                        $display("[TB] FAIL load_mid t=%0t seg/an/fd got %h/%h/%b want %h/%h/%b",
                                 $time, seg, an, frame_done, exp_seg, exp_an, exp_fd);
                    end
                end
                vectors++;
                if (seg !== ((f == 0) ? want_4321[d] : want_abcd[d])) begin
                    miscompares++;
                    $display("[TB] FAIL load_mid_frame%0d_digit%0d got seg=%h want %h",
                             f, d, seg, (f == 0) ? want_4321[d] : want_abcd[d]);
                end
            end
        end
    endtask

    task automatic test_fault();
        for (int c = 0; c < 4; c++) drive(4'b0001, 1'b0, 16'h0);
        for (int c = 0; c < 3; c++) begin
            drive(4'b0110, 1'b0, 16'h0);
            vectors++;
            if (seg !== 7'h7F || an !== 4'hF) begin
                miscompares++;
                $display("[TB] FAIL fault_blank got seg=%h an=%h want 7f/f", seg, an);
            end
        end
        vectors++;
        if (fault !== FAULT_EN || err_cnt !== (FAULT_EN ? 8'd1 : 8'd0)) begin
            miscompares++;
            $display("[TB] FAIL fault_first got fault=%b err=%h want %b/%h",
                     fault, err_cnt, FAULT_EN, FAULT_EN ? 8'd1 : 8'd0);
        end
        for (int c = 0; c < 4; c++) begin
            drive(4'b0010, 1'b0, 16'h0);
            vectors++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                miscompares++;
                $display("[TB] FAIL fault_recover c=%0d got %h/%h want %h/%h", c, seg, an, exp_seg, exp_an);
            end
        end
        vectors++;
        if (seg !== 7'h46 || an !== 4'b1101) begin
            miscompares++;
            $display("[TB] FAIL fault_redrive got seg=%h an=%h want 46/d", seg, an);
        end
        drive(4'b1111, 1'b0, 16'h0);
        drive(4'b0100, 1'b0, 16'h0);
        vectors++;
        if (err_cnt !== (FAULT_EN ? 8'd2 : 8'd0)) begin
            miscompares++;
            $display("[TB] FAIL fault_second got err=%h want %h", err_cnt, FAULT_EN ? 8'd2 : 8'd0);
        end
        for (int c = 0; c < 3; c++) drive(4'b0100, 1'b0, 16'h0);
    endtask

    task automatic test_frame_done();
        logic [3:0] oh, last;
        int wraps, pulses;
        wraps  = 0;
        pulses = 0;
        last   = phase;
        for (int f = 0; f < 3; f++) begin
            for (int d = 0; d < 4; d++) begin
                oh = 4'b0001 << d;
                if (last == 4'b1000 && oh == 4'b0001) wraps++;
                for (int c = 0; c < 2; c++) begin
                    drive(oh, 1'b0, 16'h0);
                    if (frame_done === 1'b1) pulses++;
                    vectors++;
                    if (frame_done !== exp_fd) begin
                        miscompares++;
                        $display("[TB] FAIL frame_done t=%0t got %b want %b", $time, frame_done, exp_fd);
                    end
                end
                last = oh;
            end
        end
        vectors++;
        if (pulses != wraps) begin
            miscompares++;
            $display("[TB] FAIL frame_done_count got %0d want %0d", pulses, wraps);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) drive(4'b0001, 1'b0, 16'h0);
        for (int c = 0; c < 4; c++) drive(4'b0010, 1'b0, 16'h0);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (seg !== 7'h7F || an !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL async_reset got seg=%h an=%h want 7f/f", seg, an);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0001, 1'b0, 16'h0);
            vectors++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                miscompares++;
                $display("[TB] FAIL post_reset c=%0d got %h/%h want %h/%h", c, seg, an, exp_seg, exp_an);
            end
        end
        vectors++;
        if (seg !== 7'h40 || an !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL post_reset_digit0 got seg=%h an=%h want 40/e", seg, an);
        end
    endtask

    task automatic test_err_saturate();
        for (int k = 0; k < 260; k++) begin
            drive(4'b0101, 1'b0, 16'h0);
            drive(4'b0001, 1'b0, 16'h0);
        end
        vectors++;
        if (err_cnt !== (FAULT_EN ? 8'hFF : 8'h00) || fault !== FAULT_EN) begin
            miscompares++;
            $display("[TB] FAIL err_saturate got err=%h fault=%b want %h/%b",
                     err_cnt, fault, FAULT_EN ? 8'hFF : 8'h00, FAULT_EN);
        end
        vectors++;
        if (err_cnt !== 8'(m_err)) begin
            miscompares++;
            $display("[TB] FAIL err_model got %h want %h", err_cnt, 8'(m_err));
        end
    endtask

    task automatic test_random();
        int d, dwell;
        logic [3:0] p;
        d = 0;
        dwell = 0;
        for (int n = 0; n < 400; n++) begin
            if (dwell == 0) begin
                d = (d + 1) % 4;
                dwell = $urandom_range(1, 6);
            end
            dwell--;
            if ($urandom_range(0, 19) == 0) p = 4'(illegal_tab[$urandom_range(0, 11)]);
            else p = 4'b0001 << d;
            drive(p, ($urandom_range(0, 4) == 0), 16'($urandom));
            vectors++;
            if ({seg, an, frame_done, fault, err_cnt} !==
                {exp_seg, exp_an, exp_fd, m_fault, 8'(m_err)}) begin
                miscompares++;
                $display("[TB] FAIL random n=%0d seg/an/fd/fault/err got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h",
                         n, seg, an, frame_done, fault, err_cnt,
                         exp_seg, exp_an, exp_fd, m_fault, 8'(m_err));
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        phase      = 4'h0;
        load       = 1'b0;
        digit_data = 16'h0;
        model_reset();
        test_reset();
        test_scan();
        test_load_mid_frame();
        test_fault();
        test_frame_done();
        test_async_reset();
        test_err_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
